if_fetch_queue: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Each cycle it reads the 16-bit instruction at the current PC from an internal synchronous instruction memory and pushes {pc, instruction} into a small FIFO.
- The decode stage drains the FIFO through a valid/ready handshake.
- The block raises pc_stall so the PC can be held, and drops all speculative entries when a taken branch (PCsrc) flushes it.

---
 rtl/if_fetch_queue_if.sv | 30 +++
 rtl/if_fetch_queue.sv | 84 ++++++++
 tb/tb_if_fetch_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: PC/flush from the program counter, program-load port,
// and the decode-side valid/ready channel.
interface if_fetch_queue_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [AW-1:0] pc;
  logic          flush;
  logic          pc_stall;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  // Decode channel: an entry transfers on any rising edge where dec_valid and
  // dec_ready are both high; dec_valid never depends on dec_ready, and
  // dec_instr/dec_pc are stable while dec_valid is high and no transfer occurs.
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;

  modport master (
    output pc, flush, imem_we, imem_waddr, imem_wdata, dec_ready,
    input  pc_stall, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    input  pc, flush, imem_we, imem_waddr, imem_wdata, dec_ready,
    output pc_stall, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: synchronous instruction memory feeding a small FIFO
// drained by decode, with credit-based PC stall and branch flush.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] fifo_instr [DEPTH];
  logic [AW-1:0] fifo_pc [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          req_valid;
  logic [AW-1:0] req_pc;
  logic [CW:0]   credit;
  logic          issue;
  logic          push;
  logic          pop;

  // The in-flight request already owns a slot, so it is counted against DEPTH.
  assign credit       = {1'b0, count} + {{CW{1'b0}}, req_valid};
  assign bus.pc_stall = (credit >= DEPTH_C);
  assign issue        = !bus.flush && !bus.pc_stall;
  assign push         = req_valid && !bus.flush;
  assign bus.dec_valid = (count != '0);
  assign pop          = bus.dec_valid && bus.dec_ready;
  assign bus.dec_instr = fifo_instr[rd_ptr];
  assign bus.dec_pc    = fifo_pc[rd_ptr];

  // Nonblocking read and write give old-data on a same-address collision.
  always_ff @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
    if (issue) mem_rdata <= mem[bus.pc];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (bus.flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= issue;
      if (issue) req_pc <= bus.pc;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entries are cleared on reset so the head reads back as zero immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed and randomised bench for if_fetch_queue with an in-order scoreboard
// of issued {pc, instruction} pairs.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.AW(AW), .DW(DW)) bus ();
  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard: every issued fetch not yet delivered or flushed, oldest first
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    mem_model [2**AW];
  logic [AW-1:0]    cur_pc = '0;
  logic             m_rv = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic fl, input logic rdy, input logic [AW-1:0] tgt);
    logic exp_stall, exp_valid, issue;
    logic [AW+DW-1:0] head;
    bus.flush      = fl;
    bus.dec_ready  = rdy;
    bus.pc         = cur_pc;
    bus.imem_we    = wr_en;
    bus.imem_waddr = wr_addr;
    bus.imem_wdata = wr_data;
    #1;
    exp_stall = (exp_q.size() >= DEPTH);
    exp_valid = (exp_q.size() > int'(m_rv));
    check("pc_stall", 32'(bus.pc_stall), 32'(exp_stall));
    check("dec_valid", 32'(bus.dec_valid), 32'(exp_valid));
    if (exp_valid && rdy) begin
      head = exp_q.pop_front();
      check("dec_pc", 32'(bus.dec_pc), 32'(head[AW+DW-1:DW]));
      check("dec_instr", 32'(bus.dec_instr), 32'(head[DW-1:0]));
    end
    issue = !fl && !exp_stall;
    if (fl) begin
      exp_q.delete();
      m_rv = 1'b0;
      cur_pc = tgt;
    end else begin
      if (issue) begin
        exp_q.push_back({cur_pc, mem_model[cur_pc]});
        cur_pc = cur_pc + 1'b1;
      end
      m_rv = issue;
    end
    if (wr_en) mem_model[wr_addr] = wr_data;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd0);
    check({tag, "_dec_pc"},    32'(bus.dec_pc),    32'd0);
    check({tag, "_dec_instr"}, 32'(bus.dec_instr), 32'd0);
    check({tag, "_pc_stall"},  32'(bus.pc_stall),  32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    bus.pc = '0;
    bus.flush = 1'b0;
    bus.dec_ready = 1'b0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    #1;
    check_reset_outputs("rst0");

    // program load while held in reset
    @(posedge clk);
    #1;
    for (int i = 0; i < 2**AW; i++) begin
      d = (i < 8) ? DW'(16'h1000 + i) : DW'($urandom_range(0, 16'hffff));
      mem_model[i] = d;
      bus.imem_we = 1'b1;
      bus.imem_waddr = AW'(i);
      bus.imem_wdata = d;
      @(posedge clk);
      #1;
    end
    bus.imem_we = 1'b0;
    check_reset_outputs("rst_load");

    // streaming with decode always ready
    reset = 1'b1;
    cur_pc = '0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, '0);

    // decode stalled: queue fills with pc 0..3, then drains
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);
    check("full_head_pc", 32'(bus.dec_pc), 32'h0);
    check("full_stall", 32'(bus.pc_stall), 32'h1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);

    // flush with three entries plus an in-flight request, restart at 0x40
    cycle(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 8'h40);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);

    // flush in the same cycle as a pop: head delivered, rest dropped
    cycle(1'b1, 1'b0, 8'h60);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 8'h80);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);

    // full queue with toggling ready, pc wrapping past 0xff
    cycle(1'b1, 1'b0, 8'hfc);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 2 == 0), '0);

    // random ready, flushes and program writes (some colliding with the fetch)
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        wr_en = 1'b1;
        wr_addr = ($urandom_range(0, 1) == 0) ? cur_pc : AW'($urandom_range(0, 2**AW-1));
        wr_data = DW'($urandom_range(0, 16'hffff));
      end
      cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 2**AW-1)));
    end

    // asynchronous reset with two entries queued
    cycle(1'b1, 1'b0, 8'h30);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    check("pre_reset_valid", 32'(bus.dec_valid), 32'h1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    m_rv = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cur_pc = 8'h20;
    bus.flush = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
